// File: rtl/tx_timer_pkg.sv
// Shared types and USB default timing constants for the TX bit timer.
// Contents: tx_tmr_state_t state encoding, USB_CLKS_PER_BIT, USB_EOP_BITS.
package tx_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        EOP  = 2'd2
    } tx_tmr_state_t;

    localparam int unsigned USB_CLKS_PER_BIT = 8;
    localparam int unsigned USB_EOP_BITS     = 3;

endpackage

// File: rtl/tx_bit_timer_if.sv
// Handshake bundle between the TX controller/encoder and the TX bit timer.
// master: controller side (drives start/num_words/abort/stuff_bit, sees strobes)
// slave : timer side (consumes requests, drives load/shift/stuff/word_done/eop/busy/done)
interface tx_bit_timer_if #(
    parameter int unsigned MAX_WORDS = 64
);
    localparam int unsigned NW = $clog2(MAX_WORDS + 1);

    logic          start;
    logic [NW-1:0] num_words;
    logic          abort;
    logic          stuff_bit;
    logic          load_enable;
    logic          shift_enable;
    logic          stuff_enable;
    logic          word_done;
    logic          eop_active;
    logic          busy;
    logic          done;

    modport master (
        output start, num_words, abort, stuff_bit,
        input  load_enable, shift_enable, stuff_enable, word_done,
               eop_active, busy, done
    );

    modport slave (
        input  start, num_words, abort, stuff_bit,
        output load_enable, shift_enable, stuff_enable, word_done,
               eop_active, busy, done
    );

endinterface

// File: rtl/tx_rollover_counter.sv
// Up-counter that wraps to 0 after reaching rollover_val.
// Ports: clk, n_rst, clear (priority over count_enable), count_enable,
//        rollover_val, count, rollover_flag (registered: count == rollover_val).
module tx_rollover_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             count_enable,
    input  logic [WIDTH-1:0] rollover_val,
    output logic [WIDTH-1:0] count,
    output logic             rollover_flag
);

    logic [WIDTH-1:0] count_d;

    // Next count: clear wins, otherwise step and wrap at rollover_val.
    always_comb begin
        count_d = count;
        if (clear) begin
            count_d = '0;
        end else if (count_enable) begin
            count_d = (count == rollover_val) ? '0 : count + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count         <= '0;
            rollover_flag <= 1'b0;
        end else begin
            count         <= count_d;
            rollover_flag <= (count_d == rollover_val);
        end
    end

endmodule

// File: rtl/tx_bit_timer.sv
// USB TX bit-timing generator: paces the shift register at CLKS_PER_BIT clocks
// per bit, requests words, inserts stuffed bit periods and appends EOP.
// Ports: clk, n_rst (async, active-low), bus (tx_bit_timer_if.slave).
// Every strobe is a flop loaded one cycle ahead, so no input reaches an output
// combinationally.
module tx_bit_timer
    import tx_timer_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT  = USB_CLKS_PER_BIT,
    parameter int unsigned BITS_PER_WORD = 8,
    parameter int unsigned MAX_WORDS     = 64,
    parameter int unsigned EOP_BITS      = USB_EOP_BITS
) (
    input  logic          clk,
    input  logic          n_rst,
    tx_bit_timer_if.slave bus
);

    localparam int unsigned CW         = $clog2(CLKS_PER_BIT);
    localparam int unsigned BW         = $clog2(BITS_PER_WORD);
    localparam int unsigned WW         = $clog2(MAX_WORDS + 1);
    localparam int unsigned EOP_CYCLES = EOP_BITS * CLKS_PER_BIT;
    localparam int unsigned EW         = $clog2(EOP_CYCLES);

    tx_tmr_state_t state_q, state_d;
    logic [WW-1:0] word_tgt_q, word_tgt_d;
    logic [WW-1:0] last_word_idx;

    logic load_q, shift_q, stuff_q, wdone_q, eop_q, busy_q, done_q;
    logic load_d, shift_d, stuff_d, wdone_d, eop_d, busy_d, done_d;

    logic [CW-1:0] clk_cnt;
    logic [BW-1:0] bit_cnt;
    logic [WW-1:0] word_cnt;
    logic [EW-1:0] eop_cnt;
    logic          clk_wrap, bit_wrap, word_wrap, eop_wrap;
    logic          pre_boundary;

    assign last_word_idx = WW'(word_tgt_q - WW'(1));
    // Outputs for the boundary cycle are decided one cycle early.
    assign pre_boundary  = (clk_cnt == CW'(CLKS_PER_BIT - 2));

    // Next-state and next-strobe logic.
    always_comb begin
        state_d    = state_q;
        word_tgt_d = word_tgt_q;
        load_d     = 1'b0;
        shift_d    = 1'b0;
        stuff_d    = 1'b0;
        wdone_d    = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start && (bus.num_words != '0)) begin
                    state_d    = RUN;
                    word_tgt_d = (bus.num_words > WW'(MAX_WORDS)) ? WW'(MAX_WORDS)
                                                                 : bus.num_words;
                    load_d     = 1'b1;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else begin
                    // Last bit of the last word is being shifted right now.
                    if (clk_wrap && shift_q && bit_wrap && word_wrap) begin
                        state_d = EOP;
                    end
                    if (pre_boundary) begin
                        stuff_d = bus.stuff_bit;
                        shift_d = !bus.stuff_bit;
                        wdone_d = !bus.stuff_bit && (bit_cnt == BW'(BITS_PER_WORD - 1));
                        load_d  = wdone_d && (word_cnt != last_word_idx);
                    end
                end
            end
            EOP: begin
                // eop_cnt is pre-incremented on EOP entry, so it returns to 0
                // exactly in the final EOP cycle.
                if (bus.abort || (eop_cnt == '0)) begin
                    state_d = IDLE;
                end else begin
                    done_d = eop_wrap;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        eop_d  = (state_d == EOP);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            word_tgt_q <= '0;
            load_q     <= 1'b0;
            shift_q    <= 1'b0;
            stuff_q    <= 1'b0;
            wdone_q    <= 1'b0;
            eop_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_tgt_q <= word_tgt_d;
            load_q     <= load_d;
            shift_q    <= shift_d;
            stuff_q    <= stuff_d;
            wdone_q    <= wdone_d;
            eop_q      <= eop_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Position within the current bit period.
    tx_rollover_counter #(.WIDTH(CW)) u_clk_cnt (
        .clk(clk), .n_rst(n_rst),
        .clear(state_d == IDLE), .count_enable(state_q == RUN),
        .rollover_val(CW'(CLKS_PER_BIT - 1)),
        .count(clk_cnt), .rollover_flag(clk_wrap)
    );

    // Data bits shifted in the current word; stuffed periods do not count.
    tx_rollover_counter #(.WIDTH(BW)) u_bit_cnt (
        .clk(clk), .n_rst(n_rst),
        .clear(state_d == IDLE), .count_enable(shift_q),
        .rollover_val(BW'(BITS_PER_WORD - 1)),
        .count(bit_cnt), .rollover_flag(bit_wrap)
    );

    // Words completed; flag marks the last word of the packet.
    tx_rollover_counter #(.WIDTH(WW)) u_word_cnt (
        .clk(clk), .n_rst(n_rst),
        .clear(state_d == IDLE), .count_enable(wdone_q),
        .rollover_val(last_word_idx),
        .count(word_cnt), .rollover_flag(word_wrap)
    );

    // EOP interval timer.
    tx_rollover_counter #(.WIDTH(EW)) u_eop_cnt (
        .clk(clk), .n_rst(n_rst),
        .clear(state_d != EOP), .count_enable(state_d == EOP),
        .rollover_val(EW'(EOP_CYCLES - 1)),
        .count(eop_cnt), .rollover_flag(eop_wrap)
    );

    assign bus.load_enable  = load_q;
    assign bus.shift_enable = shift_q;
    assign bus.stuff_enable = stuff_q;
    assign bus.word_done    = wdone_q;
    assign bus.eop_active   = eop_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;

endmodule

// File: tb/tb_tx_bit_timer.sv
// Directed bench for tx_bit_timer with CLKS_PER_BIT=4, BITS_PER_WORD=8,
// MAX_WORDS=64, EOP_BITS=3. Cycle 0 is the first RUN cycle after start.
module tb_tx_bit_timer;

    localparam int unsigned MW = 64;

    logic clk;
    logic n_rst;
    int   checks = 0;
    int   errors = 0;

    tx_bit_timer_if #(.MAX_WORDS(MW)) bus ();

    tx_bit_timer #(
        .CLKS_PER_BIT (4),
        .BITS_PER_WORD(8),
        .MAX_WORDS    (MW),
        .EOP_BITS     (3)
    ) dut (
        .clk  (clk),
        .n_rst(n_rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {load, shift, stuff, word_done, eop_active, busy, done}
    function automatic logic [6:0] outs();
        return {bus.load_enable, bus.shift_enable, bus.stuff_enable, bus.word_done,
                bus.eop_active, bus.busy, bus.done};
    endfunction

    function automatic logic [6:0] mk(input logic l, input logic s, input logic st,
                                      input logic w, input logic e, input logic b,
                                      input logic d);
        return {l, s, st, w, e, b, d};
    endfunction

    // Expected strobes for an unstuffed single-word packet.
    function automatic logic [6:0] single(input int c);
        return mk(c == 0, (c < 32) && (c % 4 == 3), 1'b0, c == 31,
                  (c >= 32) && (c <= 43), c <= 43, c == 43);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one cycle; returns positioned at cycle 0.
    task automatic launch(input int nw);
        bus.start     = 1'b1;
        bus.num_words = 7'(nw);
        step();
        bus.start     = 1'b0;
    endtask

    initial begin
        int wd;
        int done_at;

        n_rst         = 1'b0;
        bus.start     = 1'b0;
        bus.num_words = '0;
        bus.abort     = 1'b0;
        bus.stuff_bit = 1'b0;
        step();
        step();
        chk("reset_state", 32'(outs()), 32'h0);
        n_rst = 1'b1;
        step();
        chk("idle_after_reset", 32'(outs()), 32'h0);

        // Two-word packet.
        launch(2);
        for (int c = 0; c < 80; c++) begin
            chk($sformatf("two_word c%0d", c), 32'(outs()),
                32'(mk(c == 0 || c == 31, (c < 64) && (c % 4 == 3), 1'b0,
                       c == 31 || c == 63, (c >= 64) && (c <= 75), c <= 75, c == 75)));
            step();
        end

        // One stuffed bit in the third bit period.
        launch(1);
        for (int c = 0; c < 52; c++) begin
            bus.stuff_bit = (c == 10);
            chk($sformatf("stuff c%0d", c), 32'(outs()),
                32'(mk(c == 0, (c <= 35) && (c % 4 == 3) && (c != 11), c == 11,
                       c == 35, (c >= 36) && (c <= 47), c <= 47, c == 47)));
            step();
        end
        bus.stuff_bit = 1'b0;

        // Abort mid-word, then a fresh packet.
        launch(4);
        for (int c = 0; c < 28; c++) begin
            bus.abort = (c == 20);
            chk($sformatf("abort c%0d", c), 32'(outs()),
                32'(mk(c == 0, (c <= 20) && (c % 4 == 3), 1'b0, 1'b0, 1'b0,
                       c <= 20, 1'b0)));
            step();
        end
        bus.abort = 1'b0;
        launch(1);
        for (int c = 0; c < 46; c++) begin
            chk($sformatf("after_abort c%0d", c), 32'(outs()), 32'(single(c)));
            step();
        end

        // Zero-length start and abort while idle.
        bus.start     = 1'b1;
        bus.num_words = '0;
        bus.abort     = 1'b1;
        step();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("zero_words c%0d", c), 32'(outs()), 32'h0);
            step();
        end

        // Start while busy must not change the packet.
        launch(1);
        for (int c = 0; c < 46; c++) begin
            bus.start     = (c == 5);
            bus.num_words = 7'(3);
            chk($sformatf("start_busy c%0d", c), 32'(outs()), 32'(single(c)));
            step();
        end
        bus.start = 1'b0;

        // Oversize length clamps to MAX_WORDS.
        launch(100);
        wd      = 0;
        done_at = -1;
        for (int c = 0; c < 2200; c++) begin
            if (bus.word_done) wd++;
            if (bus.done && (done_at < 0)) done_at = c;
            step();
        end
        chk("clamp_word_done_count", 32'(wd), 32'd64);
        chk("clamp_done_cycle", 32'(done_at), 32'd2059);
        chk("clamp_idle", 32'(outs()), 32'h0);

        // Asynchronous reset during EOP.
        launch(2);
        for (int c = 0; c < 68; c++) step();
        chk("pre_reset_eop", 32'(outs()), 32'(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0)));
        n_rst = 1'b0;
        #1;
        chk("async_reset", 32'(outs()), 32'h0);
        step();
        n_rst = 1'b1;
        for (int c = 0; c < 20; c++) begin
            chk($sformatf("post_reset c%0d", c), 32'(outs()), 32'h0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tx_bit_timer.md
Name: tx_bit_timer

Overview:
Parameterised bit-timing generator for the USB transmit path; the next generation of the single-flop TX timer. It paces the TX shift register at CLKS_PER_BIT clocks per bit and requests each new word from the TX FIFO/encoder. It inserts bit-stuff periods on request and appends the end-of-packet (EOP) bit periods. It sits between the TX controller (start/abort/word count) and the TX shift register and NRZI encoder.

Parameters:
CLKS_PER_BIT, 8, system clocks per serial bit period; legal values are 2 or more.
BITS_PER_WORD, 8, serial bits per loaded word.
MAX_WORDS, 64, largest packet length in words.
EOP_BITS, 3, bit periods of EOP signalling after the last word.

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
start  in  1  one-cycle packet start request; honoured in IDLE only
num_words  in  $clog2(MAX_WORDS+1)  packet length in words; sampled with start
abort  in  1  cancels the current packet
stuff_bit  in  1  encoder requests a stuffed bit for the next bit period
load_enable  out  1  one-cycle pulse: load the next word into the shift register
shift_enable  out  1  one-cycle pulse: shift out one data bit
stuff_enable  out  1  one-cycle pulse: emit a stuffed 0 instead of shifting
word_done  out  1  one-cycle pulse on the last bit of each word
eop_active  out  1  level, high for the whole EOP interval
busy  out  1  high from RUN entry until return to IDLE
done  out  1  one-cycle pulse on the final EOP cycle

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0. A reset in the middle of a packet aborts it immediately and asserts no done.
- All outputs come from flops. There is no combinational path from any input to any output.
- States are IDLE, RUN and EOP.
- IDLE:
  - start=1 with num_words != 0: capture num_words into word_tgt and go to RUN. Values above MAX_WORDS are clamped to MAX_WORDS.
  - In the first RUN cycle, clk_cnt=0 and load_enable=1.
  - start with num_words=0 is ignored.
- clk_cnt counts 0..CLKS_PER_BIT-1 and wraps. The boundary cycle is the cycle with clk_cnt == CLKS_PER_BIT-1.
- stuff_bit is sampled on the edge that enters the boundary cycle, i.e. while clk_cnt == CLKS_PER_BIT-2.
- RUN boundary cycle, stuff_bit was 1: stuff_enable=1. bit_cnt does not advance, so the word stretches by one bit period.
- RUN boundary cycle, stuff_bit was 0: shift_enable=1 and bit_cnt increments.
- Last bit of a word (bit_cnt == BITS_PER_WORD-1):
  - word_done=1, bit_cnt wraps to 0, word_cnt increments.
  - If more words remain, load_enable=1 in the same cycle, so there is no gap between words.
  - If this is the last word, go to EOP with clk_cnt=0 and load_enable=0.
- EOP: eop_active=1 for EOP_BITS*CLKS_PER_BIT cycles. done=1 in the final cycle, then return to IDLE; busy falls in the next cycle.
- stuff_bit is ignored during EOP.
- abort in RUN or EOP:
  - Next cycle is IDLE; every pulse output and eop_active read 0 and done is never asserted.
  - abort has priority over a boundary occurring in the same cycle.
  - abort in IDLE has no effect.
- start while busy is ignored, and the captured word_tgt is unchanged.
- Counter widths: clk_cnt $clog2(CLKS_PER_BIT), bit_cnt $clog2(BITS_PER_WORD), word_cnt $clog2(MAX_WORDS+1), eop_cnt $clog2(EOP_BITS*CLKS_PER_BIT). Comparisons are unsigned and equality-based; no overflow is possible within legal parameters.

Decomposition:
- Shared package tx_timer_pkg holds:
  - the state enum tx_tmr_state_t {IDLE, RUN, EOP};
  - the default constants USB_CLKS_PER_BIT=8 and USB_EOP_BITS=3.
- One sub-module, tx_rollover_counter: parameterised width, clear, count_enable, rollover value and a registered rollover flag. It is instantiated for clk_cnt, bit_cnt, word_cnt and eop_cnt.

Test Plan:
Common setup for all scenarios: CLKS_PER_BIT=4, BITS_PER_WORD=8, EOP_BITS=3; cycle 0 is the first RUN cycle.
- Two-word packet: start, num_words=2 -> load_enable at cycles 0 and 31; shift_enable at 3,7,...,63 (16 pulses); word_done at 31 and 63; eop_active for cycles 64-75; done at 75; busy=0 from 76.
- Stuffing: num_words=1, stuff_bit high while clk_cnt=2 of the third bit period -> stuff_enable at 11; shift_enable at 3,7,15,...,35 (8 pulses); word_done at 35; done at 47.
- Abort: num_words=4, abort at cycle 20 -> all outputs 0 and busy=0 from cycle 21; no done; a new start afterwards produces load_enable at its own cycle 0.
- Edge cases: start with num_words=0 -> busy stays 0. start during RUN -> packet length unchanged, done at the expected cycle. num_words=100 -> exactly 64 word_done pulses.
- Reset mid-EOP: n_rst low at cycle 68 -> every output 0 immediately and asynchronously; no done pulse after release.
